// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC/PRId, trap decision for the M-stage instruction, mtc0/mfc0/eret.
// Optional Count/Compare timer on IP[15] when CP0_TIMER_EN is defined.
module cp0 #(
  parameter logic [31:0] PRID = 32'h2020_0C07
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;

  logic [5:0]  ip_in;
  logic        int_pend;
  logic        exc_pend;
  logic        wr_en;
  logic [31:0] epc_trap;
  logic [31:0] count_rd;
  logic [31:0] compare_rd;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_pend;
  logic [31:0] count_inc;

  assign count_inc  = count_q + 32'd1;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
  assign ip_in      = {HWInt[5] | timer_pend, HWInt[4:0]};

  // Free-running counter; an mtc0 load beats the increment, Compare write clears the pending bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      timer_pend <= 1'b0;
    end else begin
      if (wr_en && (A2 == REG_COUNT)) begin
        count_q <= DIn;
      end else begin
        count_q <= count_inc;
        if (count_inc == compare_q) timer_pend <= 1'b1;
      end
      if (wr_en && (A2 == REG_COMPARE)) begin
        compare_q  <= DIn;
        timer_pend <= 1'b0;
      end
    end
  end
`else
  assign count_rd   = 32'd0;
  assign compare_rd = 32'd0;
  assign ip_in      = HWInt;
`endif

  assign int_pend = sr_ie & (|(ip_in & sr_im));
  assign exc_pend = (ExcCode != 5'd0);
  assign IntReq   = ~reset & ~sr_exl & (int_pend | exc_pend);
  // A trap on this edge swallows any mtc0 issued alongside it.
  assign wr_en    = We & ~IntReq;
  assign epc_trap = BD ? (PC - 32'd4) : PC;
  assign EPC      = epc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      cause_ip <= ip_in;
      if (IntReq) begin
        sr_exl    <= 1'b1;
        cause_bd  <= BD;
        cause_exc <= int_pend ? 5'd0 : ExcCode;
        epc_q     <= {epc_trap[31:2], 2'b00};
      end else begin
        if (wr_en && (A2 == REG_SR)) begin
          sr_im  <= DIn[15:10];
          sr_ie  <= DIn[0];
          sr_exl <= DIn[1];
        end
        // eret takes EXL over a same-edge SR write.
        if (EXLClr) sr_exl <= 1'b0;
        if (wr_en && (A2 == REG_EPC)) epc_q <= {DIn[31:2], 2'b00};
      end
    end
  end

  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_COUNT:   DOut = count_rd;
      REG_COMPARE: DOut = compare_rd;
      REG_SR:      DOut = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
      REG_CAUSE:   DOut = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'b00};
      REG_EPC:     DOut = epc_q;
      REG_PRID:    DOut = PRID;
      default:     DOut = 32'd0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{DIn, epc_trap[1:0]};

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0; exercises the timer too when CP0_TIMER_EN is defined.
module tb_cp0;

  localparam logic [31:0] PRID = 32'h2020_0C07;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  a1, a2;
  logic [31:0] din;
  logic        we;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  exc_code;
  logic [5:0]  hwint;
  logic        exl_clr;
  logic        int_req;
  logic [31:0] epc;
  logic [31:0] dout;

  int n_checks = 0;
  int n_fails  = 0;

  cp0 #(.PRID(PRID)) dut (
    .clk(clk), .reset(reset), .A1(a1), .A2(a2), .DIn(din), .We(we),
    .PC(pc), .BD(bd), .ExcCode(exc_code), .HWInt(hwint), .EXLClr(exl_clr),
    .IntReq(int_req), .EPC(epc), .DOut(dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] r, output logic [31:0] v);
    a1 = r;
    #1;
    v = dout;
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b1; a1 = 5'd15; a2 = 5'd0; din = 32'd0; we = 1'b0;
    pc = 32'd0; bd = 1'b0; exc_code = 5'd12; hwint = 6'd0; exl_clr = 1'b0;
    tick(); tick();
    rd(5'd15, v); check("reset_prid", v, PRID);
    check("reset_intreq", 32'(int_req), 32'd0);
    check("reset_epc", epc, 32'd0);
    rd(5'd12, v); check("reset_sr", v, 32'd0);
    reset = 1'b0; exc_code = 5'd0;
    tick();

    // Overflow trap
    pc = 32'h3010; bd = 1'b0; exc_code = 5'd12;
    #1 check("ov_intreq", 32'(int_req), 32'd1);
    tick();
    check("ov_epc", epc, 32'h3010);
    rd(5'd13, v); check("ov_cause", v, 32'h0000_0030);
    rd(5'd12, v); check("ov_sr", v, 32'h0000_0002);
    check("ov_exl_blocks", 32'(int_req), 32'd0);

    exc_code = 5'd0; exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    rd(5'd12, v); check("eret_sr", v, 32'd0);

    // Delay slot
    exc_code = 5'd12; bd = 1'b1; pc = 32'h3024;
    tick();
    exc_code = 5'd0; bd = 1'b0;
    check("bd_epc", epc, 32'h3020);
    rd(5'd13, v); check("bd_cause", v, 32'h8000_0030);

    // eret and SR write together: EXL cleared, IM/IE from data
    exl_clr = 1'b1; we = 1'b1; a2 = 5'd12; din = 32'h0000_0403;
    tick();
    we = 1'b0; exl_clr = 1'b0;
    rd(5'd12, v); check("eret_sr_write", v, 32'h0000_0401);
    check("idle_intreq", 32'(int_req), 32'd0);

    // Interrupt beats exception; mtc0 on the trap edge is dropped
    hwint = 6'b000001; exc_code = 5'd10; pc = 32'h3100;
    we = 1'b1; a2 = 5'd14; din = 32'h0000_1234;
    #1 check("int_intreq", 32'(int_req), 32'd1);
    tick();
    we = 1'b0; exc_code = 5'd0;
    check("int_epc", epc, 32'h3100);
    rd(5'd13, v); check("int_cause", v, 32'h0000_0400);
    rd(5'd12, v); check("int_sr", v, 32'h0000_0403);

    // eret with HWInt still high re-raises IntReq
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    check("eret_reassert", 32'(int_req), 32'd1);
    rd(5'd12, v); check("eret_sr2", v, 32'h0000_0401);

    // Mask with IE=0
    hwint = 6'd0; we = 1'b1; a2 = 5'd12; din = 32'h0000_0400;
    #1 check("drop_intreq", 32'(int_req), 32'd0);
    tick();
    we = 1'b0; hwint = 6'h3f;
    #1 check("ie0_mask", 32'(int_req), 32'd0);
    tick();
    rd(5'd13, v); check("ip_track", v, 32'h0000_FC00);
    hwint = 6'd0;
    tick();

    // mtc0 / mfc0
    we = 1'b1; a2 = 5'd14; din = 32'h0000_3007;
    tick();
    rd(5'd14, v); check("mtc0_epc", v, 32'h0000_3004);
    check("epc_port", epc, 32'h0000_3004);
    a2 = 5'd13; din = 32'hFFFF_FFFF;
    tick();
    we = 1'b0;
    rd(5'd13, v); check("cause_ro", v, 32'd0);
    rd(5'd15, v); check("prid", v, PRID);
    rd(5'd3, v); check("unmapped", v, 32'd0);
`ifndef CP0_TIMER_EN
    rd(5'd9, v); check("count_off", v, 32'd0);
`else
    // Timer
    we = 1'b1; a2 = 5'd11; din = 32'd5;
    tick();
    a2 = 5'd9; din = 32'd0;
    tick();
    a2 = 5'd12; din = 32'h0000_8001;
    tick();
    we = 1'b0;
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 12 && !hit; i++) begin
        rd(5'd9, v);
        if (v == 32'd5) hit = 1'b1;
        else begin
          check("timer_early", 32'(int_req), 32'd0);
          tick();
        end
      end
      check("timer_reached", 32'(hit), 32'd1);
    end
    check("timer_intreq", 32'(int_req), 32'd1);
    tick();
    rd(5'd13, v); check("timer_ip15", 32'(v[15]), 32'd1);
    we = 1'b1; a2 = 5'd11; din = 32'd1000;
    tick();
    we = 1'b0; exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    check("timer_clear", 32'(int_req), 32'd0);
`endif

    // Reset aborts a pending trap
    exc_code = 5'd12; pc = 32'h5000;
    #1 check("pre_reset_intreq", 32'(int_req), 32'd1);
    #1 reset = 1'b1;
    #1 check("reset_abort_intreq", 32'(int_req), 32'd0);
    check("reset_abort_epc", epc, 32'd0);
    rd(5'd12, v); check("reset_abort_sr", v, 32'd0);
    tick();
    reset = 1'b0; exc_code = 5'd0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
